// File: rtl/lcd_pkg.sv
// Shared types and constants for the character-LCD arbiter family.
package lcd_pkg;

    typedef enum logic [1:0] {
        ST_IDLE      = 2'd0,
        ST_WAIT_IDLE = 2'd1,
        ST_PRESENT   = 2'd2
    } lcd_state_e;

    localparam int LCD_DATA_W      = 9;
    localparam int LCD_RS_BIT      = 8;
    localparam int LCD_TIMEOUT_DEF = 4096;

    // Index width that stays at least one bit for single-entry ranges.
    function automatic int idx_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin picker: first set request at or after ptr, wrapping.
module rr_pick
    import lcd_pkg::*;
#(
    parameter int N  = 2,
    parameter int IW = idx_w(N)
) (
    input  logic [N-1:0]  req,
    input  logic [IW-1:0] ptr,
    output logic [N-1:0]  pick,
    output logic [IW-1:0] pick_idx,
    output logic          pick_any
);

    int j;

    // Scan from the farthest candidate back to ptr so the nearest one wins.
    always_comb begin
        pick     = '0;
        pick_idx = '0;
        pick_any = 1'b0;
        j        = 0;
        for (int k = N - 1; k >= 0; k--) begin
            j        = (int'(ptr) + k) % N;
            pick     = req[j] ? (N'(1'b1) << j) : pick;
            pick_idx = req[j] ? IW'(j) : pick_idx;
            pick_any = pick_any | req[j];
        end
    end

endmodule

// File: rtl/lcd_arbiter.sv
// Burst-granular round-robin arbiter feeding one character-LCD driver
// over the data_ready / lcd_busy handshake, with a stalled-byte watchdog.
module lcd_arbiter
    import lcd_pkg::*;
#(
    parameter int NUM_REQ = 2,
    parameter int DATA_W  = LCD_DATA_W,
    parameter int TIMEOUT = LCD_TIMEOUT_DEF
) (
    input  logic                      clock,
    input  logic                      internal_reset_n,
    input  logic [NUM_REQ-1:0]        req,
    input  logic [NUM_REQ-1:0]        req_last,
    input  logic [NUM_REQ*DATA_W-1:0] req_data,
    output logic [NUM_REQ-1:0]        grant,
    output logic [NUM_REQ-1:0]        ack,
    input  logic                      lcd_busy,
    output logic [DATA_W-1:0]         lcd_data,
    output logic                      data_ready,
    output logic                      timeout_err
);

    localparam int PW = idx_w(NUM_REQ);
    localparam int TW = idx_w(TIMEOUT);

    lcd_state_e          state_q, state_d;
    logic [NUM_REQ-1:0]  grant_q, grant_d;
    logic [PW-1:0]       gidx_q, gidx_d;
    logic [PW-1:0]       ptr_q, ptr_d;
    logic [NUM_REQ-1:0]  ack_q, ack_d;
    logic [DATA_W-1:0]   lcd_data_q, lcd_data_d;
    logic                data_ready_q, data_ready_d;
    logic                timeout_err_q, timeout_err_d;
    logic [TW-1:0]       timer_q, timer_d;
    logic                release_q, release_d;
    logic                last_q, last_d;
    logic                busy_q;

    logic [NUM_REQ-1:0]  pick_s;
    logic [PW-1:0]       pick_idx_s;
    logic                pick_any_s;
    logic                busy_rise_s;

    function automatic logic [PW-1:0] next_ptr(input logic [PW-1:0] g);
        return (int'(g) >= NUM_REQ - 1) ? PW'(0) : g + PW'(1);
    endfunction

    rr_pick #(
        .N  (NUM_REQ),
        .IW (PW)
    ) u_rr_pick (
        .req      (req),
        .ptr      (ptr_q),
        .pick     (pick_s),
        .pick_idx (pick_idx_s),
        .pick_any (pick_any_s)
    );

    assign busy_rise_s = lcd_busy & ~busy_q;

    // Next-state and output decode for the grant/present handshake.
    always_comb begin
        state_d       = state_q;
        grant_d       = grant_q;
        gidx_d        = gidx_q;
        ptr_d         = ptr_q;
        ack_d         = '0;
        lcd_data_d    = lcd_data_q;
        data_ready_d  = data_ready_q;
        timeout_err_d = timeout_err_q;
        timer_d       = timer_q;
        release_d     = release_q;
        last_d        = last_q;
        case (state_q)
            ST_IDLE: begin
                if (pick_any_s) begin
                    grant_d   = pick_s;
                    gidx_d    = pick_idx_s;
                    release_d = 1'b0;
                    state_d   = ST_WAIT_IDLE;
                end else begin
                    grant_d = '0;
                end
            end
            ST_WAIT_IDLE: begin
                // A dropped req between bytes is a clean abort of the burst.
                if (lcd_busy) begin
                    state_d = ST_WAIT_IDLE;
                end else if (release_q || !req[gidx_q]) begin
                    grant_d = '0;
                    ptr_d   = next_ptr(gidx_q);
                    state_d = ST_IDLE;
                end else begin
                    lcd_data_d   = req_data[int'(gidx_q)*DATA_W +: DATA_W];
                    last_d       = req_last[gidx_q];
                    data_ready_d = 1'b1;
                    timer_d      = '0;
                    state_d      = ST_PRESENT;
                end
            end
            ST_PRESENT: begin
                if (busy_rise_s) begin
                    data_ready_d = 1'b0;
                    ack_d        = grant_q;
                    release_d    = last_q;
                    state_d      = ST_WAIT_IDLE;
                end else if (timer_q == TW'(TIMEOUT - 1)) begin
                    data_ready_d  = 1'b0;
                    timeout_err_d = 1'b1;
                    grant_d       = '0;
                    ptr_d         = next_ptr(gidx_q);
                    state_d       = ST_IDLE;
                end else begin
                    timer_d = timer_q + TW'(1);
                end
            end
            default: begin
                state_d      = ST_IDLE;
                grant_d      = '0;
                data_ready_d = 1'b0;
            end
        endcase
    end

    // Registered state and outputs with synchronous active-low reset.
    always_ff @(posedge clock) begin
        if (!internal_reset_n) begin
            state_q       <= ST_IDLE;
            grant_q       <= '0;
            gidx_q        <= '0;
            ptr_q         <= '0;
            ack_q         <= '0;
            lcd_data_q    <= '0;
            data_ready_q  <= 1'b0;
            timeout_err_q <= 1'b0;
            timer_q       <= '0;
            release_q     <= 1'b0;
            last_q        <= 1'b0;
            busy_q        <= 1'b0;
        end else begin
            state_q       <= state_d;
            grant_q       <= grant_d;
            gidx_q        <= gidx_d;
            ptr_q         <= ptr_d;
            ack_q         <= ack_d;
            lcd_data_q    <= lcd_data_d;
            data_ready_q  <= data_ready_d;
            timeout_err_q <= timeout_err_d;
            timer_q       <= timer_d;
            release_q     <= release_d;
            last_q        <= last_d;
            busy_q        <= lcd_busy;
        end
    end

    assign grant       = grant_q;
    assign ack         = ack_q;
    assign lcd_data    = lcd_data_q;
    assign data_ready  = data_ready_q;
    assign timeout_err = timeout_err_q;

endmodule

// File: tb/tb_lcd_arbiter.sv
// Scoreboard bench for lcd_arbiter: two requesters, a behavioural LCD, TIMEOUT=16.
module tb_lcd_arbiter;

    localparam int NR = 2;
    localparam int DW = 9;
    localparam int TO = 16;

    logic              clock = 1'b0;
    logic              internal_reset_n;
    logic [NR-1:0]     req;
    logic [NR-1:0]     req_last;
    logic [NR*DW-1:0]  req_data;
    logic [NR-1:0]     grant;
    logic [NR-1:0]     ack;
    logic              lcd_busy;
    logic [DW-1:0]     lcd_data;
    logic              data_ready;
    logic              timeout_err;

    int checks   = 0;
    int failures = 0;
    int ack_cnt [NR];
    logic lcd_en;
    logic [9:0] q0 [$];
    logic [9:0] q1 [$];
    logic [9:0] exp_data [$];
    logic [1:0] exp_ack [$];
    logic dr_prev;

    always #5 clock = ~clock;

    lcd_arbiter #(
        .NUM_REQ (NR),
        .DATA_W  (DW),
        .TIMEOUT (TO)
    ) dut (
        .clock            (clock),
        .internal_reset_n (internal_reset_n),
        .req              (req),
        .req_last         (req_last),
        .req_data         (req_data),
        .grant            (grant),
        .ack              (ack),
        .lcd_busy         (lcd_busy),
        .lcd_data         (lcd_data),
        .data_ready       (data_ready),
        .timeout_err      (timeout_err)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] want);
        checks++;
        if (act !== want) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, want);
        end
    endtask

    function automatic void drive_heads();
        if (q0.size() > 0) begin
            req_data[DW-1:0] = q0[0][8:0];
            req_last[0]      = q0[0][9];
        end
        if (q1.size() > 0) begin
            req_data[2*DW-1:DW] = q1[0][8:0];
            req_last[1]         = q1[0][9];
        end
    endfunction

    task automatic add(input int r, input logic [8:0] d, input logic last);
        if (r == 0) q0.push_back({last, d});
        else        q1.push_back({last, d});
        drive_heads();
    endtask

    task automatic expect_byte(input int r, input logic [8:0] d, input logic acked);
        exp_data.push_back({r[0], d});
        if (acked) exp_ack.push_back((r == 0) ? 2'b01 : 2'b10);
    endtask

    task automatic wait_grant(input logic [1:0] val, input int maxc, input string name);
        int n;
        n = 0;
        while (grant !== val && n < maxc) begin
            @(negedge clock);
            n++;
        end
        chk(name, 32'(grant), 32'(val));
    endtask

    task automatic wait_dr(input int maxc, input string name);
        int n;
        n = 0;
        while (data_ready !== 1'b1 && n < maxc) begin
            @(negedge clock);
            n++;
        end
        chk(name, 32'(data_ready), 32'd1);
    endtask

    task automatic wait_ack0(input int maxc, input string name);
        int n;
        n = 0;
        while (ack[0] !== 1'b1 && n < maxc) begin
            @(negedge clock);
            n++;
        end
        chk(name, 32'(ack[0]), 32'd1);
    endtask

    task automatic do_reset(input int cycles);
        internal_reset_n = 1'b0;
        repeat (cycles) @(negedge clock);
        internal_reset_n = 1'b1;
    endtask

    task automatic chk_cleared(input string tag);
        chk({tag, "_grant"},       32'(grant),       32'd0);
        chk({tag, "_ack"},         32'(ack),         32'd0);
        chk({tag, "_data_ready"},  32'(data_ready),  32'd0);
        chk({tag, "_lcd_data"},    32'(lcd_data),    32'd0);
        chk({tag, "_timeout_err"}, 32'(timeout_err), 32'd0);
    endtask

    // LCD model: busy rises two cycles after data_ready and lasts 20 cycles.
    initial begin
        lcd_busy = 1'b0;
        forever begin
            @(posedge clock); #1;
            if (lcd_en && data_ready && !lcd_busy) begin
                @(posedge clock); #1;
                lcd_busy = 1'b1;
                repeat (20) @(posedge clock);
                #1;
                lcd_busy = 1'b0;
            end
        end
    end

    // Requester model: advance to the next byte on ack, drop req after the last.
    initial begin
        forever begin
            @(posedge clock); #1;
            if (ack[0] === 1'b1 && q0.size() > 0) begin
                void'(q0.pop_front());
                if (q0.size() == 0) req[0] = 1'b0;
            end
            if (ack[1] === 1'b1 && q1.size() > 0) begin
                void'(q1.pop_front());
                if (q1.size() == 0) req[1] = 1'b0;
            end
            drive_heads();
        end
    end

    // Monitor: compare every presented byte and every ack against the scoreboard.
    initial begin
        logic [9:0] e;
        logic [1:0] a;
        dr_prev = 1'b0;
        forever begin
            @(negedge clock);
            if (internal_reset_n === 1'b1 && data_ready === 1'b1 && !dr_prev) begin
                if (exp_data.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL unexpected_byte: got 0x%0h with no byte expected", lcd_data);
                end else begin
                    e = exp_data.pop_front();
                    chk("byte_data", 32'(lcd_data), 32'(e[8:0]));
                    chk("byte_owner", 32'(grant), e[9] ? 32'd2 : 32'd1);
                end
            end
            if (internal_reset_n === 1'b1 && ack !== 2'b00) begin
                if (exp_ack.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL unexpected_ack: got 0x%0h with no ack expected", ack);
                end else begin
                    a = exp_ack.pop_front();
                    chk("ack", 32'(ack), 32'(a));
                end
                if (ack[0] === 1'b1) ack_cnt[0]++;
                if (ack[1] === 1'b1) ack_cnt[1]++;
            end
            dr_prev = (data_ready === 1'b1);
        end
    end

    initial begin
        int base;
        int n;
        internal_reset_n = 1'b0;
        req      = '0;
        req_last = '0;
        req_data = '0;
        lcd_en   = 1'b1;
        ack_cnt[0] = 0;
        ack_cnt[1] = 0;
        @(negedge clock);
        do_reset(3);
        chk_cleared("reset");

        // Single burst from requester 0.
        add(0, 9'h041, 1'b0); add(0, 9'h042, 1'b0); add(0, 9'h143, 1'b1);
        expect_byte(0, 9'h041, 1'b1); expect_byte(0, 9'h042, 1'b1); expect_byte(0, 9'h143, 1'b1);
        req[0] = 1'b1;
        wait_grant(2'b01, 3, "t1_grant_on");
        wait_grant(2'b00, 200, "t1_release");
        chk("t1_acks", 32'(ack_cnt[0]), 32'd3);
        chk("t1_release_after_busy_fall", 32'(lcd_busy), 32'd0);

        // Simultaneous request with ptr=1: requester 1 first.
        add(0, 9'h050, 1'b0); add(0, 9'h151, 1'b1);
        add(1, 9'h060, 1'b0); add(1, 9'h161, 1'b1);
        expect_byte(1, 9'h060, 1'b1); expect_byte(1, 9'h161, 1'b1);
        expect_byte(0, 9'h050, 1'b1); expect_byte(0, 9'h151, 1'b1);
        req = 2'b11;
        wait_grant(2'b10, 3, "t2b_r1_first");
        wait_grant(2'b01, 200, "t2b_then_r0");
        wait_grant(2'b00, 200, "t2b_done");

        // Contention from ptr=0 after reset: requester 0 first.
        do_reset(1);
        chk_cleared("reset2");
        add(0, 9'h031, 1'b0); add(0, 9'h032, 1'b1);
        add(1, 9'h1A0, 1'b0); add(1, 9'h0A1, 1'b1);
        expect_byte(0, 9'h031, 1'b1); expect_byte(0, 9'h032, 1'b1);
        expect_byte(1, 9'h1A0, 1'b1); expect_byte(1, 9'h0A1, 1'b1);
        req = 2'b11;
        wait_grant(2'b01, 3, "t2_r0_first");
        wait_grant(2'b10, 200, "t2_then_r1");
        wait_grant(2'b00, 200, "t2_done");

        // Requester 1 rises mid-burst: no interleave.
        base = ack_cnt[0];
        add(0, 9'h021, 1'b0); add(0, 9'h022, 1'b0); add(0, 9'h023, 1'b1);
        expect_byte(0, 9'h021, 1'b1); expect_byte(0, 9'h022, 1'b1); expect_byte(0, 9'h023, 1'b1);
        expect_byte(1, 9'h0C1, 1'b1); expect_byte(1, 9'h0C2, 1'b1);
        req[0] = 1'b1;
        wait_ack0(40, "t3_first_ack");
        add(1, 9'h0C1, 1'b0); add(1, 9'h0C2, 1'b1);
        req[1] = 1'b1;
        wait_grant(2'b10, 200, "t3_r1_after_r0");
        chk("t3_r0_burst_complete", 32'(ack_cnt[0] - base), 32'd3);
        wait_grant(2'b00, 200, "t3_done");

        // Abort: requester 0 drops req after its first ack.
        add(0, 9'h070, 1'b0); add(0, 9'h071, 1'b0); add(0, 9'h172, 1'b1);
        expect_byte(0, 9'h070, 1'b1);
        req[0] = 1'b1;
        wait_ack0(40, "t4_first_ack");
        req[0] = 1'b0;
        q0.delete();
        wait_grant(2'b00, 100, "t4_abort_release");
        chk("t4_release_busy_low", 32'(lcd_busy), 32'd0);
        chk("t4_no_data_ready", 32'(data_ready), 32'd0);
        add(0, 9'h080, 1'b1);
        add(1, 9'h090, 1'b1);
        expect_byte(1, 9'h090, 1'b1); expect_byte(0, 9'h080, 1'b1);
        req = 2'b11;
        wait_grant(2'b10, 3, "t4_ptr_is_1");
        wait_grant(2'b01, 200, "t4_then_r0");
        wait_grant(2'b00, 200, "t4_done");

        // Timeout: LCD never goes busy.
        lcd_en = 1'b0;
        add(0, 9'h0AA, 1'b1);
        expect_byte(0, 9'h0AA, 1'b0);
        req[0] = 1'b1;
        wait_dr(6, "t5_present");
        n = 0;
        while (data_ready === 1'b1 && n < 40) begin
            @(negedge clock);
            n++;
        end
        req[0] = 1'b0;
        q0.delete();
        chk("t5_dr_cycles", 32'(n), 32'd16);
        chk("t5_timeout_err", 32'(timeout_err), 32'd1);
        chk("t5_grant_released", 32'(grant), 32'd0);
        repeat (5) @(negedge clock);
        chk("t5_timeout_sticky", 32'(timeout_err), 32'd1);
        chk("t5_idle_after", 32'(data_ready), 32'd0);

        // Reset while a byte is presented.
        add(0, 9'h0BB, 1'b1);
        expect_byte(0, 9'h0BB, 1'b0);
        req[0] = 1'b1;
        wait_dr(6, "t6_present");
        repeat (3) @(negedge clock);
        chk("t6_still_presenting", 32'(data_ready), 32'd1);
        req[0] = 1'b0;
        q0.delete();
        do_reset(1);
        chk_cleared("t6_reset");
        repeat (4) @(negedge clock);
        chk("t6_stays_idle_grant", 32'(grant), 32'd0);
        chk("t6_stays_idle_dr", 32'(data_ready), 32'd0);

        chk("scoreboard_bytes_left", 32'(exp_data.size()), 32'd0);
        chk("scoreboard_acks_left", 32'(exp_ack.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
